clk_div_monitor: RTL and testbench

Downstream checker for the synchronous mod-N clock dividers (for example, the divide-by-6 stage). It samples the divided clock in the source clock domain and measures each period and high time in source-clock cycles. It compares both against a programmed ratio and reports lock, fault and the fault cause. It sits next to each divider instance and feeds status logic or the bench scoreboard.

---
 rtl/clk_div_monitor_pkg.sv | 18 +
 rtl/clk_div_monitor_if.sv | 28 ++
 rtl/clk_div_monitor_edge_sync_detect.sv | 42 ++++
 rtl/clk_div_monitor.sv | 189 ++++++++++++++++++
 tb/tb_clk_div_monitor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_monitor_pkg.sv
// clk_div_monitor shared types
// FSM state encoding and fault cause codes
package clk_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_CHECK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [1:0] FC_CFG    = 2'b00;
  localparam logic [1:0] FC_PERIOD = 2'b01;
  localparam logic [1:0] FC_DUTY   = 2'b10;
  localparam logic [1:0] FC_STUCK  = 2'b11;

endpackage

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor control/status bundle
// master drives stimulus and config, slave is the monitor
interface clk_div_monitor_if #(
  parameter int CW = 8
);
  logic          clk_div_in;
  logic          enable;
  logic [CW-1:0] div_ratio;
  logic          clr_fault;
  logic          locked;
  logic          fault;
  logic [1:0]    fault_code;
  logic [CW-1:0] meas_period;
  logic [CW-1:0] meas_high;
  logic          period_valid;

  modport master (
    output clk_div_in, enable, div_ratio, clr_fault,
    input  locked, fault, fault_code,
    input  meas_period, meas_high, period_valid
  );

  modport slave (
    input  clk_div_in, enable, div_ratio, clr_fault,
    output locked, fault, fault_code,
    output meas_period, meas_high, period_valid
  );
endinterface

// File: rtl/clk_div_monitor_edge_sync_detect.sv
// edge_sync_detect: optional synchronizer plus
// one-cycle delayed copy for rise/fall detection
module edge_sync_detect #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);
  logic r_sd;

  generate
    if (STAGES == 0) begin : g_direct
      assign o_s = i_d;
    end else begin : g_sync
      logic [STAGES-1:0] r_sync;
      // shift the async input through the synchronizer chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_d;
          for (int i = 1; i < STAGES; i++)
            r_sync[i] <= r_sync[i-1];
        end
      end
      assign o_s = r_sync[STAGES-1];
    end
  endgenerate

  // previous sample of s for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sd <= 1'b0;
    else        r_sd <= o_s;
  end

  assign o_rise = o_s & ~r_sd;
  assign o_fall = ~o_s & r_sd;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period/high time of a
// divided clock and tracks lock against the ratio
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CW          = 8,
  parameter int SYNC_STAGES = 0,
  parameter int LOCK_CNT    = 4
) (
  input logic         clk,
  input logic         rst_n,
  clk_div_monitor_if.slave bus
);
  logic          w_s, w_rise, w_fall, w_edge;
  logic [CW:0]   r_per_cnt, r_hi_cnt, r_idle_cnt;
  logic [CW-1:0] r_ratio;
  logic [CW-1:0] r_meas_per, r_meas_hi;
  logic          r_pv;
  state_t        r_state, w_state_nx;
  logic [1:0]    r_code, w_code_nx;
  logic [3:0]    r_good, w_good_nx;
  logic [3:0]    w_good_inc;
  logic [CW+1:0] w_per_full, w_hi_full;
  logic [CW+1:0] w_idle_nx, w_limit;
  logic [CW-1:0] w_per_meas, w_hi_meas;
  logic [CW-1:0] w_half, w_half_up;
  logic          w_per_ok, w_hi_ok, w_good_per;
  logic          w_mon, w_stuck, w_meas_en;

  edge_sync_detect #(.STAGES(SYNC_STAGES)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (bus.clk_div_in),
    .o_s    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_edge = w_rise | w_fall;
  assign w_mon  = (r_state == ST_ACQUIRE) ||
                  (r_state == ST_CHECK) ||
                  (r_state == ST_LOCKED);

  // the rise cycle itself is part of the period
  // and is also the first high cycle
  assign w_per_full = {1'b0, r_per_cnt} + 1'b1;
  assign w_hi_full  = {1'b0, r_hi_cnt} + 1'b1;
  assign w_per_meas = |w_per_full[CW+1:CW] ?
                      '1 : w_per_full[CW-1:0];
  assign w_hi_meas  = |w_hi_full[CW+1:CW] ?
                      '1 : w_hi_full[CW-1:0];

  assign w_half     = r_ratio >> 1;
  assign w_half_up  = w_half + {{(CW-1){1'b0}}, r_ratio[0]};
  assign w_per_ok   = (w_per_meas == r_ratio);
  assign w_hi_ok    = (w_hi_meas == w_half) ||
                      (w_hi_meas == w_half_up);
  assign w_good_per = w_per_ok & w_hi_ok;
  assign w_good_inc = r_good + 4'd1;

  // stuck once idle_cnt would reach 2N at this edge
  assign w_idle_nx  = {1'b0, r_idle_cnt} + 1'b1;
  assign w_limit    = {1'b0, r_ratio, 1'b0};
  assign w_stuck    = w_mon & ~w_edge &
                      (w_idle_nx >= w_limit);

  assign w_meas_en  = w_rise & bus.enable &
                      ((r_state == ST_CHECK) ||
                       (r_state == ST_LOCKED));

  // free-running period, high-time and idle counters;
  // idle count is held at zero while not monitoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt  <= '0;
      r_hi_cnt   <= '0;
      r_idle_cnt <= '0;
    end else begin
      if (w_rise)             r_per_cnt <= '0;
      else if (~&r_per_cnt)   r_per_cnt <= r_per_cnt + 1'b1;
      if (w_rise)             r_hi_cnt <= '0;
      else if (w_s && ~&r_hi_cnt)
                              r_hi_cnt <= r_hi_cnt + 1'b1;
      if (!w_mon || w_edge)   r_idle_cnt <= '0;
      else if (~&r_idle_cnt)  r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // capture measurements and ratio
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_per <= '0;
      r_meas_hi  <= '0;
      r_pv       <= 1'b0;
      r_ratio    <= '0;
    end else begin
      r_pv <= w_meas_en;
      if (w_meas_en) begin
        r_meas_per <= w_per_meas;
        r_meas_hi  <= w_hi_meas;
      end
      if (r_state == ST_IDLE && bus.enable)
        r_ratio <= bus.div_ratio;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_code  <= FC_CFG;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_code  <= w_code_nx;
      r_good  <= w_good_nx;
    end
  end

  // FSM next state; fault entry beats clr_fault
  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_code;
    w_good_nx  = r_good;
    if (!bus.enable) begin
      w_state_nx = ST_IDLE;
      w_code_nx  = FC_CFG;
      w_good_nx  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.div_ratio < CW'(2)) begin
            w_state_nx = ST_FAULT;
            w_code_nx  = FC_CFG;
          end else begin
            w_state_nx = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (w_stuck) begin
            w_state_nx = ST_FAULT;
            w_code_nx  = FC_STUCK;
          end else if (w_rise) begin
            w_state_nx = ST_CHECK;
            w_good_nx  = '0;
          end
        end
        ST_CHECK: begin
          if (w_stuck) begin
            w_state_nx = ST_FAULT;
            w_code_nx  = FC_STUCK;
          end else if (w_rise) begin
            if (!w_good_per) begin
              w_good_nx = '0;
            end else if (w_good_inc == 4'(LOCK_CNT)) begin
              w_state_nx = ST_LOCKED;
              w_good_nx  = '0;
            end else begin
              w_good_nx = w_good_inc;
            end
          end
        end
        ST_LOCKED: begin
          if (w_stuck) begin
            w_state_nx = ST_FAULT;
            w_code_nx  = FC_STUCK;
          end else if (w_rise && !w_good_per) begin
            w_state_nx = ST_FAULT;
            w_code_nx  = w_per_ok ? FC_DUTY : FC_PERIOD;
          end
        end
        ST_FAULT: begin
          if (bus.clr_fault) begin
            w_state_nx = ST_ACQUIRE;
            w_code_nx  = FC_CFG;
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign bus.locked       = (r_state == ST_LOCKED);
  assign bus.fault        = (r_state == ST_FAULT);
  assign bus.fault_code   = r_code;
  assign bus.meas_period  = r_meas_per;
  assign bus.meas_high    = r_meas_hi;
  assign bus.period_valid = r_pv;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: vector table plus directed
// sequences for lock, fault causes and reset
module tb_clk_div_monitor;

  typedef struct {
    string name;
    int    ratio;
    int    hi;
    int    lo;
    int    nper;
    int    e_per;
    int    e_hi;
    int    e_lock;
    int    e_fault;
    int    e_code;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  vec_t vecs[12];

  clk_div_monitor_if #(.CW(8)) bif ();

  clk_div_monitor #(
    .CW          (8),
    .SYNC_STAGES (0),
    .LOCK_CNT    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic tick(input logic v);
    @(negedge clk);
    bif.clk_div_in = v;
  endtask

  task automatic period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) tick(1'b1);
    for (int i = 0; i < lo; i++) tick(1'b0);
  endtask

  task automatic restart(input int ratio);
    bif.enable = 1'b0;
    tick(1'b0);
    tick(1'b0);
    bif.div_ratio = 8'(ratio);
    bif.enable    = 1'b1;
    tick(1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    restart(v.ratio);
    for (int p = 0; p <= v.nper; p++) period(v.hi, v.lo);
    chk({v.name, ".per"},   int'(bif.meas_period), v.e_per);
    chk({v.name, ".hi"},    int'(bif.meas_high),   v.e_hi);
    chk({v.name, ".lock"},  int'(bif.locked),      v.e_lock);
    chk({v.name, ".fault"}, int'(bif.fault),       v.e_fault);
    chk({v.name, ".code"},  int'(bif.fault_code),  v.e_code);
  endtask

  // lock on an ideal /6 source, checking lock timing
  task automatic lock6(input string nm);
    restart(6);
    for (int p = 0; p < 4; p++) period(3, 3);
    tick(1'b1);
    chk({nm, ".prelock"}, int'(bif.locked), 0);
    tick(1'b1);
    chk({nm, ".lock"}, int'(bif.locked), 1);
    chk({nm, ".pv"}, int'(bif.period_valid), 1);
    tick(1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bif.clk_div_in = 1'b0;
    bif.enable     = 1'b0;
    bif.div_ratio  = 8'd0;
    bif.clr_fault  = 1'b0;

    vecs[0]  = '{"div6",        6, 3, 3, 4, 6, 3, 1, 0, 0};
    vecs[1]  = '{"div5_h2",     5, 2, 3, 4, 5, 2, 1, 0, 0};
    vecs[2]  = '{"div5_h3",     5, 3, 2, 4, 5, 3, 1, 0, 0};
    vecs[3]  = '{"div6_3good",  6, 3, 3, 3, 6, 3, 0, 0, 0};
    vecs[4]  = '{"div6_duty",   6, 2, 4, 4, 6, 2, 0, 0, 0};
    vecs[5]  = '{"ratio4_src6", 4, 3, 3, 4, 6, 3, 0, 0, 0};
    vecs[6]  = '{"ratio1",      1, 3, 3, 0, 6, 3, 0, 1, 0};
    vecs[7]  = '{"ratio0",      0, 3, 3, 0, 6, 3, 0, 1, 0};
    vecs[8]  = '{"div2",        2, 1, 1, 4, 2, 1, 1, 0, 0};
    vecs[9]  = '{"div7_h4",     7, 4, 3, 4, 7, 4, 1, 0, 0};
    vecs[10] = '{"div7_h2",     7, 2, 5, 4, 7, 2, 0, 0, 0};
    vecs[11] = '{"div8",        8, 4, 4, 4, 8, 4, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst.lock",  int'(bif.locked),       0);
    chk("rst.fault", int'(bif.fault),        0);
    chk("rst.code",  int'(bif.fault_code),   0);
    chk("rst.per",   int'(bif.meas_period),  0);
    chk("rst.hi",    int'(bif.meas_high),    0);
    chk("rst.pv",    int'(bif.period_valid), 0);
    rst_n = 1'b1;

    for (int k = 0; k < 12; k++) run_vec(vecs[k]);

    // stretched period while locked
    lock6("str");
    period(3, 4);
    tick(1'b1);
    chk("str.early", int'(bif.fault), 0);
    tick(1'b1);
    chk("str.fault", int'(bif.fault),       1);
    chk("str.code",  int'(bif.fault_code),  1);
    chk("str.lock",  int'(bif.locked),      0);
    chk("str.per",   int'(bif.meas_period), 7);
    chk("str.hi",    int'(bif.meas_high),   3);
    tick(1'b1);
    chk("str.pv0",   int'(bif.period_valid), 0);
    chk("str.hold",  int'(bif.fault),        1);

    // duty error, clear and relock; ratio change ignored
    lock6("duty");
    period(2, 4);
    tick(1'b1);
    tick(1'b1);
    chk("duty.fault", int'(bif.fault),      1);
    chk("duty.code",  int'(bif.fault_code), 2);
    bif.clr_fault = 1'b1;
    tick(1'b0);
    bif.clr_fault = 1'b0;
    bif.div_ratio = 8'd9;
    chk("clr.fault", int'(bif.fault),      0);
    chk("clr.code",  int'(bif.fault_code), 0);
    tick(1'b0);
    tick(1'b0);
    for (int p = 0; p < 5; p++) period(3, 3);
    chk("relock.lock",  int'(bif.locked), 1);
    chk("relock.fault", int'(bif.fault),  0);

    // stuck high after the last rise
    lock6("stk");
    tick(1'b1);
    for (int i = 0; i < 12; i++) tick(1'b1);
    chk("stk.early", int'(bif.fault),  0);
    chk("stk.lock",  int'(bif.locked), 1);
    tick(1'b1);
    chk("stk.fault", int'(bif.fault),      1);
    chk("stk.code",  int'(bif.fault_code), 3);
    chk("stk.lock0", int'(bif.locked),     0);

    // config fault one cycle after enable
    bif.enable = 1'b0;
    tick(1'b0);
    tick(1'b0);
    chk("cfg.idle", int'(bif.fault), 0);
    bif.div_ratio = 8'd1;
    bif.enable    = 1'b1;
    tick(1'b0);
    chk("cfg.fault", int'(bif.fault),      1);
    chk("cfg.code",  int'(bif.fault_code), 0);

    // async reset in CHECK, then relock
    restart(6);
    for (int p = 0; p < 3; p++) period(3, 3);
    chk("ar.pre", int'(bif.meas_period), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.lock",  int'(bif.locked),       0);
    chk("ar.fault", int'(bif.fault),        0);
    chk("ar.per",   int'(bif.meas_period),  0);
    chk("ar.hi",    int'(bif.meas_high),    0);
    chk("ar.pv",    int'(bif.period_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0);
    for (int p = 0; p < 5; p++) period(3, 3);
    chk("ar.relock", int'(bif.locked),      1);
    chk("ar.per2",   int'(bif.meas_period), 6);
    chk("ar.hi2",    int'(bif.meas_high),   3);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
